// File: rtl/nonce_feeder.sv
// rtl/nonce_feeder.sv - job-to-header feeder: one active plus one pending mining job, one header per nonce

module nonce_feeder (
    input  logic         clk,
    input  logic         rst,
    input  logic         job_valid,
    output logic         job_ready,
    input  logic [479:0] job_template,
    input  logic [31:0]  job_nonce_start,
    input  logic [31:0]  job_nonce_end,
    input  logic         abort,
    output logic         hdr_valid,
    input  logic         hdr_ready,
    output logic [511:0] header,
    output logic [31:0]  hdr_nonce,
    output logic         busy,
    output logic         exhausted,
    output logic [32:0]  issued_count
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t         state_q, state_d;
    logic [479:0]   tmpl_q, tmpl_d;
    logic [31:0]    nonce_q, nonce_d;
    logic [31:0]    end_q, end_d;
    logic           pend_full_q, pend_full_d;
    logic [479:0]   pend_tmpl_q, pend_tmpl_d;
    logic [31:0]    pend_start_q, pend_start_d;
    logic [31:0]    pend_end_q, pend_end_d;
    logic           exhausted_q, exhausted_d;
    logic [32:0]    issued_q, issued_d;

    logic hs;
    logic accept;

    assign job_ready    = !pend_full_q && !abort && !rst;
    assign hs           = (state_q == RUN) && hdr_ready;
    assign accept       = job_valid && job_ready;

    assign hdr_valid    = (state_q == RUN);
    assign busy         = (state_q == RUN);
    assign header       = {tmpl_q, nonce_q};
    assign hdr_nonce    = nonce_q;
    assign exhausted    = exhausted_q;
    assign issued_count = issued_q;

    always_comb begin
        state_d      = state_q;
        tmpl_d       = tmpl_q;
        nonce_d      = nonce_q;
        end_d        = end_q;
        pend_full_d  = pend_full_q;
        pend_tmpl_d  = pend_tmpl_q;
        pend_start_d = pend_start_q;
        pend_end_d   = pend_end_q;
        exhausted_d  = 1'b0;
        issued_d     = issued_q;

        if (abort) begin
            // A handshake coinciding with abort still counts, but never raises exhausted.
            if (hs) begin
                issued_d = issued_q + 33'd1;
            end
            state_d     = IDLE;
            pend_full_d = 1'b0;
        end else begin
            if (hs) begin
                issued_d = issued_q + 33'd1;
                if (nonce_q != end_q) begin
                    nonce_d = nonce_q + 32'd1;
                end else begin
                    exhausted_d = 1'b1;
                    if (pend_full_q) begin
                        tmpl_d      = pend_tmpl_q;
                        nonce_d     = pend_start_q;
                        end_d       = pend_end_q;
                        pend_full_d = 1'b0;
                        issued_d    = 33'd0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            // A job arriving as the last job finishes becomes active directly, avoiding a bubble.
            if (accept) begin
                if (state_d == IDLE) begin
                    tmpl_d   = job_template;
                    nonce_d  = job_nonce_start;
                    end_d    = job_nonce_end;
                    issued_d = 33'd0;
                    state_d  = RUN;
                end else begin
                    pend_tmpl_d  = job_template;
                    pend_start_d = job_nonce_start;
                    pend_end_d   = job_nonce_end;
                    pend_full_d  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            tmpl_q       <= '0;
            nonce_q      <= '0;
            end_q        <= '0;
            pend_full_q  <= 1'b0;
            pend_tmpl_q  <= '0;
            pend_start_q <= '0;
            pend_end_q   <= '0;
            exhausted_q  <= 1'b0;
            issued_q     <= '0;
        end else begin
            state_q      <= state_d;
            tmpl_q       <= tmpl_d;
            nonce_q      <= nonce_d;
            end_q        <= end_d;
            pend_full_q  <= pend_full_d;
            pend_tmpl_q  <= pend_tmpl_d;
            pend_start_q <= pend_start_d;
            pend_end_q   <= pend_end_d;
            exhausted_q  <= exhausted_d;
            issued_q     <= issued_d;
        end
    end

endmodule

// File: tb/tb_nonce_feeder.sv
// tb/tb_nonce_feeder.sv - randomized and directed check of nonce_feeder against a job-queue model

module tb_nonce_feeder;

    logic         clk = 1'b0;
    logic         rst;
    logic         job_valid;
    logic         job_ready;
    logic [479:0] job_template;
    logic [31:0]  job_nonce_start;
    logic [31:0]  job_nonce_end;
    logic         abort;
    logic         hdr_valid;
    logic         hdr_ready;
    logic [511:0] header;
    logic [31:0]  hdr_nonce;
    logic         busy;
    logic         exhausted;
    logic [32:0]  issued_count;

    always #5 clk = ~clk;

    nonce_feeder dut (
        .clk             (clk),
        .rst             (rst),
        .job_valid       (job_valid),
        .job_ready       (job_ready),
        .job_template    (job_template),
        .job_nonce_start (job_nonce_start),
        .job_nonce_end   (job_nonce_end),
        .abort           (abort),
        .hdr_valid       (hdr_valid),
        .hdr_ready       (hdr_ready),
        .header          (header),
        .hdr_nonce       (hdr_nonce),
        .busy            (busy),
        .exhausted       (exhausted),
        .issued_count    (issued_count)
    );

    typedef struct packed {
        logic [479:0] t;
        logic [31:0]  cur;
        logic [31:0]  e;
    } job_t;

    // Reference: jobs in issue order; element 0 is the active job, element 1 the pending one.
    job_t         jobs[$];
    logic [32:0]  m_count;
    logic         m_exh;
    logic [511:0] m_hdr;

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge(input logic jv, input logic [479:0] jt, input logic [31:0] js,
                              input logic [31:0] je, input logic ab, input logic hr, input logic r);
        logic ready;
        logic hsk;
        job_t nj;
        if (r) begin
            jobs.delete();
            m_count = '0;
            m_exh   = 1'b0;
            m_hdr   = '0;
            return;
        end
        ready = (jobs.size() < 2) && !ab;
        hsk   = (jobs.size() > 0) && hr;
        m_exh = 1'b0;
        if (ab) begin
            if (hsk) m_count = m_count + 33'd1;
            jobs.delete();
            return;
        end
        if (hsk) begin
            m_count = m_count + 33'd1;
            if (jobs[0].cur == jobs[0].e) begin
                m_exh = 1'b1;
                void'(jobs.pop_front());
                if (jobs.size() > 0) m_count = '0;
            end else begin
                jobs[0].cur = jobs[0].cur + 32'd1;
            end
        end
        if (jv && ready) begin
            if (jobs.size() == 0) m_count = '0;
            nj.t   = jt;
            nj.cur = js;
            nj.e   = je;
            jobs.push_back(nj);
        end
        if (jobs.size() > 0) m_hdr = {jobs[0].t, jobs[0].cur};
    endtask

    task automatic step(input logic jv, input logic [479:0] jt, input logic [31:0] js,
                        input logic [31:0] je, input logic ab, input logic hr, input logic r);
        logic exp_ready;
        job_valid       = jv;
        job_template    = jt;
        job_nonce_start = js;
        job_nonce_end   = je;
        abort           = ab;
        hdr_ready       = hr;
        rst             = r;
        exp_ready       = (jobs.size() < 2) && !ab && !r;
        #1;
        check_val("job_ready", 512'(job_ready), 512'(exp_ready));
        @(posedge clk);
        model_edge(jv, jt, js, je, ab, hr, r);
        @(negedge clk);
        check_val("hdr_valid", 512'(hdr_valid), 512'(jobs.size() > 0));
        check_val("busy", 512'(busy), 512'(jobs.size() > 0));
        check_val("exhausted", 512'(exhausted), 512'(m_exh));
        check_val("issued_count", 512'(issued_count), 512'(m_count));
        check_val("header", header, m_hdr);
        check_val("hdr_nonce", 512'(hdr_nonce), 512'(m_hdr[31:0]));
    endtask

    function automatic logic [479:0] rand_tmpl();
        logic [479:0] t;
        for (int i = 0; i < 15; i++) t[i*32 +: 32] = $urandom;
        return t;
    endfunction

    task automatic idle_cycles(input int n, input logic hr);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, 1'b0, hr, 1'b0);
    endtask

    logic [479:0] ta, tb, tc;
    logic [31:0]  rs;
    logic [31:0]  rlen;

    initial begin
        job_valid = 0; job_template = '0; job_nonce_start = '0; job_nonce_end = '0;
        abort = 0; hdr_ready = 0; rst = 1;
        m_count = '0; m_exh = 0; m_hdr = '0;
        @(negedge clk);
        step(0, '0, '0, '0, 0, 0, 1);
        step(0, '0, '0, '0, 0, 0, 1);
        idle_cycles(1, 0);

        // Basic run
        ta = {60{8'hA5}};
        step(1, ta, 32'd5, 32'd7, 0, 1, 0);
        idle_cycles(5, 1);

        // Backpressure with pattern 1,0,0,1,0,1,1
        tb = rand_tmpl();
        step(1, tb, 32'h10, 32'h13, 0, 0, 0);
        step(0, '0, '0, '0, 0, 1, 0);
        step(0, '0, '0, '0, 0, 0, 0);
        step(0, '0, '0, '0, 0, 0, 0);
        step(0, '0, '0, '0, 0, 1, 0);
        step(0, '0, '0, '0, 0, 0, 0);
        step(0, '0, '0, '0, 0, 1, 0);
        step(0, '0, '0, '0, 0, 1, 0);
        idle_cycles(2, 1);

        // Wrap and single nonce
        step(1, rand_tmpl(), 32'hFFFF_FFFE, 32'h0000_0001, 0, 1, 0);
        idle_cycles(6, 1);
        step(1, rand_tmpl(), 32'h42, 32'h42, 0, 1, 0);
        idle_cycles(3, 1);

        // Back-to-back, with job C offered during the promotion of B
        ta = rand_tmpl(); tb = rand_tmpl(); tc = rand_tmpl();
        step(1, ta, 32'd1, 32'd3, 0, 1, 0);
        step(1, tb, 32'd100, 32'd101, 0, 1, 0);
        step(1, tc, 32'd200, 32'd201, 0, 1, 0);
        step(1, tc, 32'd200, 32'd201, 0, 1, 0);
        step(0, '0, '0, '0, 0, 1, 0);
        idle_cycles(6, 1);

        // Abort at the handshake of nonce 8 with a job pending
        step(1, ta, 32'd5, 32'd20, 0, 1, 0);
        step(1, tb, 32'd50, 32'd60, 0, 1, 0);
        idle_cycles(2, 1);
        step(0, '0, '0, '0, 1, 1, 0);
        idle_cycles(3, 1);

        // Same with rst
        step(1, ta, 32'd5, 32'd20, 0, 1, 0);
        step(1, tb, 32'd50, 32'd60, 0, 1, 0);
        idle_cycles(2, 1);
        step(0, '0, '0, '0, 0, 1, 1);
        idle_cycles(3, 1);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            rlen = ($urandom_range(0, 9) == 0) ? 32'd0 : 32'($urandom_range(0, 6));
            rs   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFD : $urandom;
            step($urandom_range(0, 2) == 0, rand_tmpl(), rs, rs + rlen,
                 $urandom_range(0, 59) == 0, $urandom_range(0, 9) < 7,
                 $urandom_range(0, 299) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
